// File: rtl/miner_work_sched.sv
// Work sequencer and golden-nonce collector for a bank of double-hash miner cores.
// Sequences core reset around new work, flags nonce exhaustion and queues results round-robin.
module miner_work_sched #(
    parameter int          NUM_CORES    = 4,
    parameter int          RESET_CYCLES = 4,
    parameter logic [31:0] NONCE_LIMIT  = 32'hffff_ff00,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   work_valid,
    output logic                   work_ready,
    input  logic [255:0]           work_midstate,
    input  logic [95:0]            work_data,
    output logic [255:0]           midstate,
    output logic [95:0]            data,
    output logic                   core_reset,
    input  logic [32*NUM_CORES-1:0] core_golden,
    input  logic [31:0]            core_nonce,
    output logic                   gn_valid,
    input  logic                   gn_ready,
    output logic [31:0]            gn_nonce,
    output logic [2:0]             gn_core,
    output logic                   busy,
    output logic                   exhausted,
    output logic                   overflow
);

    // state      | meaning
    // IDLE       | no work yet, cores held in reset
    // RESET_HOLD | new work latched, cores held in reset for RESET_CYCLES
    // RUN        | cores hashing, watching nonce progress
    // EXHAUSTED  | nonce range done, cores left running until new work
    typedef enum logic [1:0] {IDLE, RESET_HOLD, RUN, EXHAUSTED} state_t;

    localparam int CW = $clog2(RESET_CYCLES);
    localparam int AW = $clog2(FIFO_DEPTH);

    state_t          state;
    logic [CW-1:0]   hold_cnt;
    logic            nonce_hi;
    logic            accept;
    logic            active;

    logic [31:0]     golden_q  [NUM_CORES];
    logic [31:0]     pend_data [NUM_CORES];
    logic [NUM_CORES-1:0] pend_v;
    logic [NUM_CORES-1:0] evt;

    logic [2:0]      rr_ptr;
    logic            sel_found;
    logic [2:0]      sel_idx;
    logic [31:0]     sel_data;

    logic [31:0]     mem_nonce [FIFO_DEPTH];
    logic [2:0]      mem_core  [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   rd_nxt;
    logic [AW:0]     count;
    logic [AW:0]     remain;
    logic            pop;
    logic            push;
    logic            can_push;

    assign accept = work_valid && work_ready;
    assign active = (state == RUN) || (state == EXHAUSTED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            nonce_hi   <= 1'b0;
            midstate   <= '0;
            data       <= '0;
            core_reset <= 1'b1;
            work_ready <= 1'b1;
            busy       <= 1'b0;
            exhausted  <= 1'b0;
        end else begin
            nonce_hi <= (core_nonce >= NONCE_LIMIT);
            if (accept) begin
                midstate   <= work_midstate;
                data       <= work_data;
                state      <= RESET_HOLD;
                hold_cnt   <= CW'(RESET_CYCLES - 1);
                core_reset <= 1'b1;
                work_ready <= 1'b0;
                busy       <= 1'b1;
                exhausted  <= 1'b0;
            end else begin
                case (state)
                    RESET_HOLD: begin
                        if (hold_cnt == '0) begin
                            state      <= RUN;
                            core_reset <= 1'b0;
                            work_ready <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt - CW'(1);
                        end
                    end
                    RUN: begin
                        if (nonce_hi) begin
                            state     <= EXHAUSTED;
                            busy      <= 1'b0;
                            exhausted <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Copying every cycle outside RUN/EXHAUSTED hides the cores' clear-to-zero on reset.
    always_comb begin
        evt = '0;
        for (int i = 0; i < NUM_CORES; i++)
            evt[i] = active && (core_golden[32*i +: 32] != golden_q[i]);
    end

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_data  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!sel_found && pend_v[i] && (3'(i) >= rr_ptr)) begin
                sel_found = 1'b1;
                sel_idx   = 3'(i);
                sel_data  = pend_data[i];
            end
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!sel_found && pend_v[i]) begin
                sel_found = 1'b1;
                sel_idx   = 3'(i);
                sel_data  = pend_data[i];
            end
        end
    end

    assign pop      = gn_valid && gn_ready;
    assign can_push = (count != (AW+1)'(FIFO_DEPTH)) || pop;
    assign push     = sel_found && can_push;
    assign rd_nxt   = rd_ptr + AW'(pop);
    assign remain   = count - (AW+1)'(pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr   <= '0;
            pend_v   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) begin
                golden_q[i]  <= '0;
                pend_data[i] <= '0;
            end
        end else begin
            if (push)
                rr_ptr <= (sel_idx == 3'(NUM_CORES - 1)) ? 3'd0 : sel_idx + 3'd1;
            for (int i = 0; i < NUM_CORES; i++) begin
                golden_q[i] <= core_golden[32*i +: 32];
                if (evt[i]) begin
                    pend_data[i] <= core_golden[32*i +: 32];
                    pend_v[i]    <= 1'b1;
                    if (pend_v[i] && !(push && (sel_idx == 3'(i))))
                        overflow <= 1'b1;
                end else if (push && (sel_idx == 3'(i))) begin
                    pend_v[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_nonce[wr_ptr] <= sel_data;
            mem_core[wr_ptr]  <= sel_idx;
        end
    end

    // Head registers carry the next-cycle head so gn_* comes straight from flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            gn_valid <= 1'b0;
            gn_nonce <= '0;
            gn_core  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_nxt;
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (remain == '0 && !push) begin
                gn_valid <= 1'b0;
            end else begin
                gn_valid <= 1'b1;
                if (remain == '0) begin
                    gn_nonce <= sel_data;
                    gn_core  <= sel_idx;
                end else begin
                    gn_nonce <= mem_nonce[rd_nxt];
                    gn_core  <= mem_core[rd_nxt];
                end
            end
        end
    end

endmodule
